// File: rtl/miniRV_pkg.sv
// Shared miniRV constants and types for the instruction-fetch slice.
package miniRV_pkg;

    localparam int XLEN        = 32;
    localparam int INSTR_BYTES = 4;

    typedef enum logic {
        BOOT,
        RUN
    } fetch_state_t;

    function automatic logic [XLEN-1:0] pc_next_seq(input logic [XLEN-1:0] pc);
        return pc + XLEN'(INSTR_BYTES);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous flush; head is presented combinationally.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == (AW+1)'(DEPTH));
    assign do_pop   = pop && !empty;
    // A push into a full FIFO is accepted when the head leaves in the same cycle.
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// miniRV instruction-fetch stage: drives the PC register, issues credit-limited
// memory requests, queues responses for decode and squashes fetches on redirect.
module fetch_unit
    import miniRV_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc_q,
    output logic [31:0] pc_d,
    output logic        pc_en,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr
);

    localparam int CW = $clog2(QDEPTH) + 1;

    fetch_state_t        state;
    logic [CW-1:0]       outstanding;
    logic [CW-1:0]       discard;
    logic [CW-1:0]       q_count;
    logic [CW-1:0]       fl_count;
    logic                credit_ok;
    logic                redirect_run;
    logic                req_hs;
    logic                rsp_accept;
    logic                q_pop;
    logic                q_empty;
    logic                q_full;
    logic                fl_empty;
    logic                fl_full;
    logic [XLEN-1:0]     fl_pc;
    logic [2*XLEN-1:0]   q_head;

    // Queue slots already claimed by in-flight requests count against the credit.
    assign credit_ok      = ({1'b0, outstanding} + {1'b0, q_count}) < (CW+1)'(QDEPTH);
    assign redirect_run   = (state == RUN) && redirect_valid;
    assign imem_req_valid = (state == RUN) && credit_ok && (discard == '0) && !redirect_valid;
    assign imem_req_addr  = pc_q;
    assign req_hs         = imem_req_valid && imem_req_ready;
    assign rsp_accept     = (state == RUN) && imem_rsp_valid && (discard == '0) && !redirect_valid;

    assign if_valid = !q_empty;
    assign q_pop    = if_valid && if_ready;
    assign if_pc    = q_head[2*XLEN-1:XLEN];
    assign if_instr = q_head[XLEN-1:0];

    always_comb begin
        pc_en = 1'b0;
        pc_d  = '0;
        if (rst_n) begin
            if (state == BOOT) begin
                pc_en = 1'b1;
                pc_d  = RESET_PC;
            end else if (redirect_valid) begin
                pc_en = 1'b1;
                pc_d  = redirect_pc;
            end else if (req_hs) begin
                pc_en = 1'b1;
                pc_d  = pc_next_seq(pc_q);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= BOOT;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            if (state == BOOT) begin
                state <= RUN;
            end
            unique case ({req_hs, imem_rsp_valid})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
            // Everything still in flight after this edge belongs to the squashed path.
            if (redirect_run) begin
                discard <= outstanding - CW'(imem_rsp_valid);
            end else if ((discard != '0) && imem_rsp_valid) begin
                discard <= discard - 1'b1;
            end
        end
    end

    sync_fifo #(
        .WIDTH (XLEN),
        .DEPTH (QDEPTH)
    ) u_inflight (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect_run),
        .push      (req_hs),
        .push_data (pc_q),
        .pop       (rsp_accept),
        .pop_data  (fl_pc),
        .empty     (fl_empty),
        .full      (fl_full),
        .count     (fl_count)
    );

    sync_fifo #(
        .WIDTH (2*XLEN),
        .DEPTH (QDEPTH)
    ) u_iqueue (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect_run),
        .push      (rsp_accept),
        .push_data ({fl_pc, imem_rsp_data}),
        .pop       (q_pop),
        .pop_data  (q_head),
        .empty     (q_empty),
        .full      (q_full),
        .count     (q_count)
    );

    a_rsp_has_space: assert property (@(posedge clk) disable iff (!rst_n)
        rsp_accept |-> !q_full);
    a_rsp_has_pc: assert property (@(posedge clk) disable iff (!rst_n)
        rsp_accept |-> !fl_empty);
    a_req_has_slot: assert property (@(posedge clk) disable iff (!rst_n)
        req_hs |-> !fl_full);
    // Only live (non-discarded) requests keep a PC in the in-flight FIFO.
    a_inflight_track: assert property (@(posedge clk) disable iff (!rst_n)
        fl_count == (outstanding - discard));

endmodule

// File: tb/tb_fetch_unit.sv
// Randomised bench for fetch_unit against a queue-based fetch model and memory model.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          QDEPTH   = 2;

    logic        clk;
    logic        rst_n;
    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic        pc_en;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_instr;

    fetch_unit #(
        .RESET_PC (RESET_PC),
        .QDEPTH   (QDEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pc_q           (pc_q),
        .pc_d           (pc_d),
        .pc_en          (pc_en),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_pc          (if_pc),
        .if_instr       (if_instr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // PC register that the fetch stage sits in front of.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      pc_q <= '0;
        else if (pc_en)  pc_q <= pc_d;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A3C_96E1;
    endfunction

    // Stimulus knobs (percentages and latency range).
    int p_ready    = 100;
    int p_ifready  = 100;
    int p_redirect = 0;
    int lat_min    = 1;
    int lat_max    = 1;

    // Memory model: in-order responses, one per accepted request.
    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;
    mreq_t mem_pend[$];
    int    last_due = 0;
    int    cyc      = 0;

    // Behavioural fetch model.
    bit          booted = 0;
    int          m_out  = 0;
    int          m_disc = 0;
    logic [31:0] m_pc   = '0;
    logic [31:0] m_infl[$];
    logic [63:0] m_q[$];

    // Observation logs for the hand-computed expectations.
    logic [31:0] hs_log[$];
    logic [31:0] pcd_log[$];
    logic [31:0] acc_log[$];

    task automatic model_check();
        bit          exp_req;
        bit          hs;
        logic [31:0] p;
        if (!rst_n) begin
            chk1("rst_pc_en", pc_en, 1'b0);
            chk1("rst_req_valid", imem_req_valid, 1'b0);
            chk1("rst_if_valid", if_valid, 1'b0);
            chk("rst_pc_d", pc_d, 32'h0);
            booted = 0;
            m_out  = 0;
            m_disc = 0;
            m_infl.delete();
            m_q.delete();
            return;
        end
        if (!booted) begin
            chk1("boot_pc_en", pc_en, 1'b1);
            chk("boot_pc_d", pc_d, RESET_PC);
            chk1("boot_req_valid", imem_req_valid, 1'b0);
            chk1("boot_if_valid", if_valid, 1'b0);
            booted = 1;
            m_pc   = RESET_PC;
            return;
        end
        exp_req = (m_out + m_q.size() < QDEPTH) && (m_disc == 0) && !redirect_valid;
        chk1("req_valid", imem_req_valid, exp_req);
        if (exp_req) chk("req_addr", imem_req_addr, m_pc);
        hs = exp_req && imem_req_ready;
        chk1("pc_en", pc_en, redirect_valid || hs);
        if (redirect_valid)  chk("pc_d_redirect", pc_d, redirect_pc);
        else if (hs)         chk("pc_d_seq", pc_d, m_pc + 32'd4);
        chk1("if_valid", if_valid, m_q.size() != 0);
        if (m_q.size() != 0) begin
            chk("if_pc", if_pc, m_q[0][63:32]);
            chk("if_instr", if_instr, m_q[0][31:0]);
        end

        if (m_q.size() != 0 && if_ready) void'(m_q.pop_front());
        if (redirect_valid) begin
            m_q.delete();
            m_infl.delete();
            m_out  = m_out - (imem_rsp_valid ? 1 : 0);
            m_disc = m_out;
            m_pc   = redirect_pc;
        end else begin
            if (imem_rsp_valid) begin
                if (m_disc > 0) begin
                    m_disc--;
                end else if (m_infl.size() != 0) begin
                    p = m_infl.pop_front();
                    m_q.push_back({p, mem_word(p)});
                end
                m_out--;
            end
            if (hs) begin
                m_infl.push_back(m_pc);
                m_out++;
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    task automatic mem_record();
        mreq_t r;
        if (!rst_n) begin
            mem_pend.delete();
            last_due = 0;
            return;
        end
        if (imem_req_valid && imem_req_ready) begin
            hs_log.push_back(imem_req_addr);
            pcd_log.push_back(pc_d);
            r.addr = imem_req_addr;
            r.due  = cyc + int'($urandom_range(lat_max, lat_min));
            if (r.due <= last_due) r.due = last_due + 1;
            last_due = r.due;
            mem_pend.push_back(r);
        end
        if (if_valid && if_ready && !redirect_valid) acc_log.push_back(if_pc);
    endtask

    task automatic drive_next();
        mreq_t   r;
        int unsigned sel;
        imem_req_ready = int'($urandom_range(0, 99)) < p_ready;
        if_ready       = int'($urandom_range(0, 99)) < p_ifready;
        redirect_valid = int'($urandom_range(0, 99)) < p_redirect;
        sel = $urandom_range(0, 7);
        if (sel == 0)      redirect_pc = 32'hFFFF_FFF8;
        else if (sel == 1) redirect_pc = $urandom;
        else               redirect_pc = 32'($urandom_range(0, 255)) << 2;
        if (rst_n && mem_pend.size() != 0 && mem_pend[0].due <= cyc) begin
            r = mem_pend.pop_front();
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(r.addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
    endtask

    task automatic step();
        @(negedge clk);
        model_check();
        mem_record();
        @(posedge clk);
        #1;
        cyc++;
        drive_next();
    endtask

    task automatic clear_logs();
        hs_log.delete();
        pcd_log.delete();
        acc_log.delete();
    endtask

    task automatic enter_reset();
        rst_n = 1'b0;
        step();
        clear_logs();
    endtask

    task automatic run_until_hs(input int n, input int max_cycles);
        for (int k = 0; k < max_cycles && hs_log.size() < n; k++) step();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n          = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        if_ready       = 1'b0;
        repeat (3) step();

        // Straight-line fetch with a one-cycle memory.
        p_ready = 100; p_ifready = 100; p_redirect = 0; lat_min = 1; lat_max = 1;
        clear_logs();
        rst_n = 1'b1;
        repeat (20) step();
        chk1("A_acc_count", acc_log.size() >= 4, 1'b1);
        chk("A_acc0", acc_log[0], 32'h0);
        chk("A_acc1", acc_log[1], 32'h4);
        chk("A_acc2", acc_log[2], 32'h8);
        chk("A_acc3", acc_log[3], 32'hC);
        chk("A_hs2", hs_log[2], 32'h8);

        // Decode stalled: exactly QDEPTH requests, then resume at 0x8.
        enter_reset();
        p_ifready = 0;
        rst_n = 1'b1;
        repeat (12) step();
        chk("B_hs_count", 32'(hs_log.size()), 32'd2);
        chk1("B_req_blocked", imem_req_valid, 1'b0);
        chk1("B_if_valid", if_valid, 1'b1);
        chk("B_head_pc", if_pc, 32'h0);
        p_ifready = 100;
        run_until_hs(3, 20);
        chk1("B_resumed", hs_log.size() >= 3, 1'b1);
        chk("B_resume_addr", hs_log[2], 32'h8);

        // Redirect with two requests in flight.
        enter_reset();
        lat_min = 3; lat_max = 3;
        rst_n = 1'b1;
        run_until_hs(2, 20);
        chk1("D_two_out", hs_log.size() == 2, 1'b1);
        clear_logs();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        for (int k = 0; k < 40 && acc_log.size() == 0; k++) step();
        chk("D_first_req", hs_log[0], 32'h200);
        chk("D_first_if_pc", acc_log[0], 32'h200);

        // PC wrap, then asynchronous reset with the queue occupied.
        enter_reset();
        lat_min = 1; lat_max = 2; p_ifready = 0;
        rst_n = 1'b1;
        repeat (3) step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        step();
        clear_logs();
        run_until_hs(2, 30);
        chk("C_wrap_addr", hs_log[0], 32'hFFFF_FFFC);
        chk("C_wrap_pc_d", pcd_log[0], 32'h0);
        chk("C_after_wrap", hs_log[1], 32'h0);
        for (int k = 0; k < 20 && !if_valid; k++) step();
        chk1("C_q_nonempty", if_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        chk1("C_rst_if_valid", if_valid, 1'b0);
        chk1("C_rst_req_valid", imem_req_valid, 1'b0);
        chk1("C_rst_pc_en", pc_en, 1'b0);
        step();

        // Randomised traffic with redirects and mid-stream resets.
        for (int r = 0; r < 8; r++) begin
            int mid;
            p_ready    = int'($urandom_range(30, 100));
            p_ifready  = int'($urandom_range(20, 100));
            p_redirect = int'($urandom_range(2, 15));
            lat_min    = 1;
            lat_max    = int'($urandom_range(1, 4));
            mid        = int'($urandom_range(50, 350));
            rst_n = 1'b0;
            step();
            rst_n = 1'b1;
            for (int i = 0; i < 400; i++) begin
                step();
                if (i == mid) begin
                    rst_n = 1'b0;
                    step();
                    rst_n = 1'b1;
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
